// File: rtl/row_pair_window_shifter_if.sv
// rtl/row_pair_window_shifter_if.sv - load/step handshake and window outputs of the row pair shifter
interface row_pair_window_shifter_if #(
  parameter int ROW_W = 512,
  parameter int POS_W = 9
);
  logic             i_load;
  logic [ROW_W-1:0] i_1st_row;
  logic [ROW_W-1:0] i_2nd_row;
  logic             i_bottom_or_top_search;
  logic             i_step;
  logic             i_abort;
  logic             o_ready;
  logic             o_valid;
  logic [ROW_W-1:0] o_1st_row_512bit;
  logic [ROW_W-1:0] o_2nd_row_512bit;
  logic             o_bottom_or_top_search;
  logic [POS_W-1:0] o_pos;
  logic             o_last;
  logic             o_done;

  modport master (
    output i_load, i_1st_row, i_2nd_row, i_bottom_or_top_search, i_step, i_abort,
    input  o_ready, o_valid, o_1st_row_512bit, o_2nd_row_512bit,
           o_bottom_or_top_search, o_pos, o_last, o_done
  );

  modport slave (
    input  i_load, i_1st_row, i_2nd_row, i_bottom_or_top_search, i_step, i_abort,
    output o_ready, o_valid, o_1st_row_512bit, o_2nd_row_512bit,
           o_bottom_or_top_search, o_pos, o_last, o_done
  );
endinterface

// File: rtl/row_pair_window_shifter.sv
// rtl/row_pair_window_shifter.sv - shifts a latched row pair so successive 3-bit windows reach the extractor
module row_pair_window_shifter #(
  parameter int ROW_W  = 512,
  parameter int STRIDE = 1,
  parameter int POS_W  = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  row_pair_window_shifter_if.slave bus
);

  localparam int               LAST_POS   = (ROW_W - 3) / STRIDE;
  localparam logic [POS_W-1:0] LAST_POS_V = POS_W'(LAST_POS);

  if (STRIDE < 1 || STRIDE > 3) begin : g_bad_stride
    $error("row_pair_window_shifter: STRIDE must be 1..3");
  end
  if ((LAST_POS >> POS_W) != 0) begin : g_bad_pos_w
    $error("row_pair_window_shifter: POS_W too narrow for LAST_POS");
  end

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row1_q, row1_d;
  logic [ROW_W-1:0] row2_q, row2_d;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row1_q  <= '0;
      row2_q  <= '0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row1_q  <= row1_d;
      row2_q  <= row2_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row1_d  = row1_q;
    row2_d  = row2_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_load) begin
          row1_d  = bus.i_1st_row;
          row2_d  = bus.i_2nd_row;
          dir_d   = bus.i_bottom_or_top_search;
          pos_d   = '0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (bus.i_abort) begin
          row1_d  = '0;
          row2_d  = '0;
          pos_d   = '0;
          state_d = ST_IDLE;
        end else if (bus.i_step) begin
          if (pos_q == LAST_POS_V) begin
            row1_d  = '0;
            row2_d  = '0;
            pos_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // bottom search walks windows into the MSB end, top search into the LSB end
            if (dir_q) begin
              row1_d = row1_q >> STRIDE;
              row2_d = row2_q >> STRIDE;
            end else begin
              row1_d = row1_q << STRIDE;
              row2_d = row2_q << STRIDE;
            end
            pos_d = pos_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_ready                = (state_q == ST_IDLE);
  assign bus.o_valid                = (state_q == ST_ACTIVE);
  assign bus.o_1st_row_512bit       = row1_q;
  assign bus.o_2nd_row_512bit       = row2_q;
  assign bus.o_bottom_or_top_search = dir_q;
  assign bus.o_pos                  = pos_q;
  assign bus.o_last                 = (state_q == ST_ACTIVE) && (pos_q == LAST_POS_V);
  assign bus.o_done                 = done_q;

endmodule

// File: tb/tb_row_pair_window_shifter.sv
// tb/tb_row_pair_window_shifter.sv - directed bench for row_pair_window_shifter at STRIDE 1 and 3
module tb_row_pair_window_shifter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  row_pair_window_shifter_if #(.ROW_W(512), .POS_W(9)) bus1 ();
  row_pair_window_shifter_if #(.ROW_W(512), .POS_W(9)) bus3 ();

  row_pair_window_shifter #(.ROW_W(512), .STRIDE(1), .POS_W(9)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  row_pair_window_shifter #(.ROW_W(512), .STRIDE(3), .POS_W(9)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [511:0] row_a, row_ones, pat1, pat2, pat_alt, exp1, exp2;

  initial begin
    row_a    = {1'b1, 508'b0, 3'b101};
    row_ones = {512{1'b1}};
    pat1     = {16{32'hA5C3_1E69}};
    pat2     = {16{32'h0F1E_2D3C}};
    pat_alt  = {{170{3'b101}}, 2'b00};

    bus1.i_load = 0; bus1.i_step = 0; bus1.i_abort = 0; bus1.i_bottom_or_top_search = 0;
    bus1.i_1st_row = '0; bus1.i_2nd_row = '0;
    bus3.i_load = 0; bus3.i_step = 0; bus3.i_abort = 0; bus3.i_bottom_or_top_search = 0;
    bus3.i_1st_row = '0; bus3.i_2nd_row = '0;

    // reset state
    rst = 1; tick(); tick();
    check("rst_ready", bus1.o_ready, 1);
    check("rst_valid", bus1.o_valid, 0);
    check("rst_pos",   bus1.o_pos, 0);
    check("rst_row1",  bus1.o_1st_row_512bit, 0);
    check("rst_row2",  bus1.o_2nd_row_512bit, 0);
    check("rst_last",  bus1.o_last, 0);
    check("rst_done",  bus1.o_done, 0);
    rst = 0;

    // step/abort ignored while idle
    bus1.i_step = 1; bus1.i_abort = 1; tick();
    check("idle_ign_ready", bus1.o_ready, 1);
    check("idle_ign_valid", bus1.o_valid, 0);
    bus1.i_abort = 0;

    // load with simultaneous step: load wins, no shift
    bus1.i_load = 1; bus1.i_1st_row = row_a; bus1.i_2nd_row = row_ones; bus1.i_bottom_or_top_search = 0;
    tick();
    bus1.i_load = 0; bus1.i_step = 0;
    check("ld0_valid", bus1.o_valid, 1);
    check("ld0_ready", bus1.o_ready, 0);
    check("ld0_pos",   bus1.o_pos, 0);
    check("ld0_r1top", bus1.o_1st_row_512bit[511:509], 3'b100);
    check("ld0_r2top", bus1.o_2nd_row_512bit[511:509], 3'b111);
    check("ld0_r1",    bus1.o_1st_row_512bit, row_a);
    bus1.i_abort = 1; tick(); bus1.i_abort = 0;
    check("ab0_ready", bus1.o_ready, 1);

    // direction 1, one step
    bus1.i_load = 1; bus1.i_bottom_or_top_search = 1; tick(); bus1.i_load = 0;
    check("ld1_dir",  bus1.o_bottom_or_top_search, 1);
    check("ld1_r1lo", bus1.o_1st_row_512bit[2:0], 3'b101);
    bus1.i_step = 1; tick(); bus1.i_step = 0;
    check("st1_pos",   bus1.o_pos, 1);
    check("st1_r1lo",  bus1.o_1st_row_512bit[2:0], 3'b010);
    check("st1_r1msb", bus1.o_1st_row_512bit[511], 0);
    check("st1_r1",    bus1.o_1st_row_512bit, {1'b0, 1'b1, 507'b0, 3'b010});
    check("st1_r2",    bus1.o_2nd_row_512bit, {1'b0, {511{1'b1}}});
    bus1.i_abort = 1; tick(); bus1.i_abort = 0;

    // full run over all 510 windows, direction 0
    bus1.i_load = 1; bus1.i_1st_row = pat1; bus1.i_2nd_row = pat2; bus1.i_bottom_or_top_search = 0;
    tick(); bus1.i_load = 0;
    check("run_last0", bus1.o_last, 0);
    bus1.i_step = 1;
    for (int k = 1; k <= 509; k++) begin
      tick();
      exp1 = pat1 << k;
      exp2 = pat2 << k;
      check("run_pos", bus1.o_pos, k);
      check("run_r1",  bus1.o_1st_row_512bit, exp1);
      check("run_r2",  bus1.o_2nd_row_512bit, exp2);
      check("run_last", bus1.o_last, (k == 509));
    end
    tick();
    bus1.i_step = 0;
    check("done_pulse", bus1.o_done, 1);
    check("done_ready", bus1.o_ready, 1);
    check("done_valid", bus1.o_valid, 0);
    check("done_r1",    bus1.o_1st_row_512bit, 0);
    check("done_r2",    bus1.o_2nd_row_512bit, 0);
    check("done_pos",   bus1.o_pos, 0);
    check("done_last",  bus1.o_last, 0);

    // back-to-back load in the done cycle
    bus1.i_load = 1; tick(); bus1.i_load = 0;
    check("b2b_done_clr", bus1.o_done, 0);
    check("b2b_valid",    bus1.o_valid, 1);
    check("b2b_r1",       bus1.o_1st_row_512bit, pat1);

    // advance to pos 5, then load attempt and a 10-cycle stall
    bus1.i_step = 1;
    repeat (5) tick();
    bus1.i_step = 0;
    bus1.i_load = 1; bus1.i_1st_row = pat2; bus1.i_2nd_row = pat1; bus1.i_bottom_or_top_search = 1;
    exp1 = pat1 << 5;
    exp2 = pat2 << 5;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_pos", bus1.o_pos, 5);
      check("stall_r1",  bus1.o_1st_row_512bit, exp1);
      check("stall_r2",  bus1.o_2nd_row_512bit, exp2);
      check("stall_dir", bus1.o_bottom_or_top_search, 0);
    end
    bus1.i_load = 0;

    // abort with step at pos 100
    bus1.i_step = 1;
    repeat (95) tick();
    bus1.i_step = 0;
    check("pre_abort_pos", bus1.o_pos, 100);
    bus1.i_abort = 1; bus1.i_step = 1; tick();
    bus1.i_abort = 0; bus1.i_step = 0;
    check("abort_ready", bus1.o_ready, 1);
    check("abort_valid", bus1.o_valid, 0);
    check("abort_pos",   bus1.o_pos, 0);
    check("abort_r1",    bus1.o_1st_row_512bit, 0);
    check("abort_done",  bus1.o_done, 0);
    tick();
    check("abort_done2", bus1.o_done, 0);

    // reset mid-ACTIVE
    bus1.i_load = 1; bus1.i_1st_row = pat1; bus1.i_bottom_or_top_search = 0; tick(); bus1.i_load = 0;
    bus1.i_step = 1; repeat (3) tick();
    check("prerst_pos", bus1.o_pos, 3);
    rst = 1; tick(); rst = 0; bus1.i_step = 0;
    check("mrst_ready", bus1.o_ready, 1);
    check("mrst_valid", bus1.o_valid, 0);
    check("mrst_pos",   bus1.o_pos, 0);
    check("mrst_r1",    bus1.o_1st_row_512bit, 0);
    check("mrst_r2",    bus1.o_2nd_row_512bit, 0);
    check("mrst_dir",   bus1.o_bottom_or_top_search, 0);
    check("mrst_last",  bus1.o_last, 0);
    check("mrst_done",  bus1.o_done, 0);

    // STRIDE 3, direction 0, alternating 101 groups
    bus3.i_load = 1; bus3.i_1st_row = pat_alt; bus3.i_2nd_row = row_ones; bus3.i_bottom_or_top_search = 0;
    tick(); bus3.i_load = 0;
    check("s3_pos0", bus3.o_pos, 0);
    check("s3_win0", bus3.o_1st_row_512bit[511:509], 3'b101);
    bus3.i_step = 1;
    for (int k = 1; k <= 169; k++) begin
      tick();
      check("s3_pos",  bus3.o_pos, k);
      check("s3_win",  bus3.o_1st_row_512bit[511:509], 3'b101);
      check("s3_last", bus3.o_last, (k == 169));
    end
    tick();
    bus3.i_step = 0;
    check("s3_done",  bus3.o_done, 1);
    check("s3_ready", bus3.o_ready, 1);
    tick();
    check("s3_done_clr", bus3.o_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/row_pair_window_shifter.md
Name: row_pair_window_shifter

Overview:
- Upstream feeder for the 3x2 block extractor of the connected-domain filter.
- Latches a pair of adjacent image rows. Each accepted step shifts both rows by STRIDE bits so that successive 3-bit column windows land in the extractor's sampled bit positions: the MSB end for bottom search, the LSB end for top search.
- Tracks the window position, flags the last window and pulses done when the row pair is exhausted.

Parameters:
- ROW_W, 512, row width in bits.
- STRIDE, 1, bits shifted per step; must be between 1 and 3.
- POS_W, 9, width of the window position counter; must satisfy 2^POS_W > LAST_POS.
- LAST_POS (derived, localparam) = (ROW_W-3)/STRIDE, integer division; default value 509.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- i_load, input, 1, load request for a new row pair.
- i_1st_row, input, ROW_W, first (upper) row.
- i_2nd_row, input, ROW_W, second (lower) row.
- i_bottom_or_top_search, input, 1, search direction sampled at load: 0 = bottom, 1 = top.
- i_step, input, 1, consumer request to advance one window.
- i_abort, input, 1, discard the current pair and return to idle.
- o_ready, output, 1, high in IDLE; a load is accepted only when this is high.
- o_valid, output, 1, high in ACTIVE; output rows hold a valid window.
- o_1st_row_512bit, output, ROW_W, shifted first row, fed to the extractor.
- o_2nd_row_512bit, output, ROW_W, shifted second row, fed to the extractor.
- o_bottom_or_top_search, output, 1, latched direction, fed to the extractor.
- o_pos, output, POS_W, index of the current window.
- o_last, output, 1, high while ACTIVE and o_pos == LAST_POS.
- o_done, output, 1, one-cycle pulse when the final window is stepped past.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State becomes IDLE.
  - Both row registers, o_pos, the latched direction, o_valid, o_last and o_done are all 0.
  - o_ready is 1.
  - Reset takes priority over every other input, including in the middle of ACTIVE.
- States: IDLE and ACTIVE.
- IDLE:
  - o_ready=1, o_valid=0.
  - i_load=1 at an edge: capture i_1st_row, i_2nd_row and i_bottom_or_top_search unshifted; set o_pos=0; go to ACTIVE. o_valid is high in the next cycle, so load latency is 1 cycle.
  - i_step and i_abort are ignored in IDLE.
  - With simultaneous i_load and i_step, the load wins and no shift occurs.
- ACTIVE:
  - o_ready=0; i_load is ignored and must not corrupt the registers.
  - Priority order: i_abort, then i_step.
  - i_abort=1: go to IDLE, clear the row registers and o_pos, no o_done pulse.
  - i_step=1 with o_pos < LAST_POS:
    - Direction 0: both rows shift left by STRIDE, zero-filled at the LSBs.
    - Direction 1: both rows shift right by STRIDE, zero-filled at the MSBs.
    - o_pos increments by 1. The new window appears on the outputs the next cycle (1-cycle step latency).
  - i_step=1 with o_pos == LAST_POS: go to IDLE, o_done=1 for exactly the next cycle, clear the rows and o_pos. o_ready is high in that same cycle.
  - i_step=0: all registers hold; the consumer may stall indefinitely.
- Outputs are registered only; there are no combinational paths from inputs to outputs.
- o_last is decoded from the registered o_pos and state, and is 0 in IDLE.
- No other counter wrap is possible: o_pos never exceeds LAST_POS.
- Window correctness invariants at position k:
  - Direction 0: output bits [ROW_W-1 : ROW_W-3] equal input bits [ROW_W-1-k*STRIDE : ROW_W-3-k*STRIDE].
  - Direction 1: output bits [2:0] equal input bits [k*STRIDE+2 : k*STRIDE].
- A back-to-back pair is possible: a load is accepted in the cycle where o_done is high, giving one idle cycle between pairs.

Test Plan:
- Reset, then load with row1 = 512'h8000...0005, row2 = all-ones, direction 0 → next cycle o_valid=1, o_pos=0, row1[511:509]=3'b100, row2[511:509]=3'b111.
- Same pair with direction 1 and one step (STRIDE=1) → o_pos=1, row1[2:0]=3'b010, row1[511]=0 (zero fill).
- Load, then 509 consecutive steps → o_last=1 at o_pos=509. One more step → o_done high for exactly 1 cycle, o_ready=1, o_valid=0, rows read 0.
- In ACTIVE at o_pos=5, assert i_load with different data, then hold i_step low for 10 cycles → rows and o_pos unchanged throughout.
- At o_pos=100, assert i_abort and i_step together → IDLE, o_pos=0, no o_done. Then assert rst mid-ACTIVE on a fresh load → all outputs reach reset values on the next edge.
- STRIDE=3, direction 0, row1 = alternating 3'b101 groups from the MSB → every window reads 3'b101; o_last at o_pos=169.
